multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle RV32I-subset datapath (FETCH/DECODE/EXEC/MEM/WB/HALT)
//
// Executes add, sub, and, or, slt, addi, lw, sw, beq and ecall (halt), one
// instruction at a time through a single registered FSM. Optional: define
// MULTICYCLE_BNE_EN to also decode bne; otherwise bne halts like any unknown
// opcode.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   imem_addr/imem_data    instruction fetch (address = PC, data combinational)
//   dmem_req/we/addr/wdata data request held until dmem_ready; addr[1:0] = 0
//   dmem_rdata/dmem_ready  load data and accept/complete strobe (MEM only)
//   halted                 high once HALT is entered
//   retired_count          completed instructions, wraps at 2^32
//   dbg_sel/dbg_data       combinational register-file peek (0 if out of range)

module multicycle_datapath #(
  parameter int          NUM_REGS   = 32,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  halted,
  output logic [31:0]           retired_count,
  input  logic [4:0]            dbg_sel,
  output logic [31:0]           dbg_data
);

  localparam int RIDX = $clog2(NUM_REGS);

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_BR   = 7'h63;

`ifdef MULTICYCLE_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic [31:0] regs [NUM_REGS];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  // x0 and indices beyond the implemented file are hard zero / not writable
  function automatic logic in_range(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NUM_REGS);
  endfunction

  logic [31:0] rs1_rd, rs2_rd;
  assign rs1_rd   = in_range(rs1)     ? regs[rs1[RIDX-1:0]]     : 32'd0;
  assign rs2_rd   = in_range(rs2)     ? regs[rs2[RIDX-1:0]]     : 32'd0;
  assign dbg_data = in_range(dbg_sel) ? regs[dbg_sel[RIDX-1:0]] : 32'd0;

  assign imem_addr  = ADDR_WIDTH'(pc);
  // alu_out and rs2_val are only reloaded in EXEC/DECODE, so both stay stable in MEM
  assign dmem_addr  = ADDR_WIDTH'({alu_out[31:2], 2'b00});
  assign dmem_wdata = rs2_val;

  logic dec_ok;
  always_comb begin
    dec_ok = 1'b0;
    case (opcode)
      OP_R:    dec_ok = ((funct7 == 7'h00) && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}))
                     || ((funct7 == 7'h20) && (funct3 == 3'b000));
      OP_ADDI: dec_ok = (funct3 == 3'b000);
      OP_LW:   dec_ok = (funct3 == 3'b010);
      OP_SW:   dec_ok = (funct3 == 3'b010);
      OP_BR:   dec_ok = (funct3 == 3'b000) || (BNE_EN && (funct3 == 3'b001));
      default: dec_ok = 1'b0;
    endcase
  end

  logic [31:0] imm_dec;
  always_comb begin
    imm_dec = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OP_SW:   imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:   imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  logic [31:0] alu_res;
  always_comb begin
    alu_res = rs1_val + imm;
    if (opcode == OP_R) begin
      case (funct3)
        3'b000:  alu_res = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
        3'b111:  alu_res = rs1_val & rs2_val;
        3'b110:  alu_res = rs1_val | rs2_val;
        3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
        default: alu_res = rs1_val + rs2_val;
      endcase
    end
  end

  // funct3[0] distinguishes bne from beq, so it inverts the equality test
  logic br_taken;
  assign br_taken = (rs1_val == rs2_val) ^ funct3[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= PC_RESET;
      ir            <= 32'd0;
      rs1_val       <= 32'd0;
      rs2_val       <= 32'd0;
      imm           <= 32'd0;
      alu_out       <= 32'd0;
      mdr           <= 32'd0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      halted        <= 1'b0;
      retired_count <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= imem_data;
          state <= DECODE;
        end
        DECODE: begin
          rs1_val <= rs1_rd;
          rs2_val <= rs2_rd;
          imm     <= imm_dec;
          if (dec_ok) begin
            state <= EXEC;
          end else begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        EXEC: begin
          alu_out <= alu_res;
          case (opcode)
            OP_LW, OP_SW: begin
              dmem_req <= 1'b1;
              dmem_we  <= (opcode == OP_SW);
              state    <= MEM;
            end
            OP_BR: begin
              pc            <= br_taken ? (pc + imm) : (pc + 32'd4);
              retired_count <= retired_count + 32'd1;
              state         <= FETCH;
            end
            default: state <= WB;
          endcase
        end
        MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              pc            <= pc + 32'd4;
              retired_count <= retired_count + 32'd1;
              state         <= FETCH;
            end else begin
              mdr   <= dmem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          if (in_range(rd)) regs[rd[RIDX-1:0]] <= (opcode == OP_LW) ? mdr : alu_out;
          pc            <= pc + 32'd4;
          retired_count <= retired_count + 32'd1;
          state         <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed self-checking bench for multicycle_datapath

module tb_multicycle_datapath;

  localparam logic [31:0] PC_RST = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready = 1'b0;
  logic        halted;
  logic [31:0] retired_count;
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] dbg_data;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];

  int          n_checks = 0;
  int          n_pass = 0;
  int          ready_delay = 0;
  int          req_len = 0;
  int          n_req = 0;
  logic [31:0] req_lens  [8];
  logic [31:0] req_addrs [8];
  logic        req_wes   [8];

  always #5 clk = ~clk;

  multicycle_datapath #(
    .NUM_REGS   (16),
    .PC_RESET   (PC_RST),
    .ADDR_WIDTH (32)
  ) u_dut (
    .clock         (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .halted        (halted),
    .retired_count (retired_count),
    .dbg_sel       (dbg_sel),
    .dbg_data      (dbg_data)
  );

  assign imem_data  = imem[imem_addr[7:2]];
  assign dmem_rdata = dmem[dmem_addr[5:2]];

  always @(posedge clk) begin
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[5:2]] <= dmem_wdata;
  end

  // Data-memory responder: ready rises on the (ready_delay+1)-th cycle of a request
  always @(negedge clk) begin
    if (dmem_req) begin
      dmem_ready = (req_len == ready_delay);
      req_len++;
      if (dmem_ready && n_req < 8) begin
        req_lens[n_req]  = 32'(req_len);
        req_addrs[n_req] = dmem_addr;
        req_wes[n_req]   = dmem_we;
        n_req++;
      end
    end else begin
      dmem_ready = 1'b0;
      req_len    = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic clear_imem(input logic [31:0] fill);
    for (int i = 0; i < 64; i++) imem[i] = fill;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pc", imem_addr, PC_RST);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_until_halt(input int max_cycles, output int cycles);
    cycles = 0;
    while (!halted && cycles < max_cycles) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    int cyc;
    int base;

    // Straight-line ALU program with halt timing
    clear_imem(ECALL);
    imem[0] = enc_addi(5'd1, 5'd0, 12'd5);
    imem[1] = enc_addi(5'd2, 5'd0, 12'd7);
    imem[2] = enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
    apply_reset();
    run_until_halt(100, cyc);
    check("t1_halt_cycle", 32'(cyc), 32'd14);
    check_reg("t1_x1", 5'd1, 32'd5);
    check_reg("t1_x2", 5'd2, 32'd7);
    check_reg("t1_x3", 5'd3, 32'd12);
    check("t1_retired", retired_count, 32'd3);
    repeat (5) @(negedge clk);
    check("t1_frozen_retired", retired_count, 32'd3);
    check("t1_frozen_pc", imem_addr, PC_RST + 32'hC);
    check("t1_frozen_req", {31'd0, dmem_req}, 32'd0);

    // Remaining R ops with a negative operand and a not-taken beq
    clear_imem(ECALL);
    imem[0] = enc_addi(5'd1, 5'd0, 12'd5);
    imem[1] = enc_addi(5'd2, 5'd0, 12'hFFD);
    imem[2] = enc_r(7'h20, 3'b000, 5'd3, 5'd1, 5'd2);
    imem[3] = enc_r(7'h00, 3'b111, 5'd4, 5'd1, 5'd2);
    imem[4] = enc_r(7'h00, 3'b110, 5'd5, 5'd1, 5'd2);
    imem[5] = enc_r(7'h00, 3'b010, 5'd6, 5'd2, 5'd1);
    imem[6] = enc_r(7'h00, 3'b010, 5'd7, 5'd1, 5'd2);
    imem[7] = enc_br(3'b000, 5'd1, 5'd2, 13'd8);
    apply_reset();
    run_until_halt(200, cyc);
    check_reg("t2_sub", 5'd3, 32'd8);
    check_reg("t2_and", 5'd4, 32'd5);
    check_reg("t2_or", 5'd5, 32'hFFFF_FFFD);
    check_reg("t2_slt_true", 5'd6, 32'd1);
    check_reg("t2_slt_false", 5'd7, 32'd0);
    check("t2_retired", retired_count, 32'd8);
    check("t2_pc", imem_addr, PC_RST + 32'h20);

    // Store then load with 3 wait cycles each
    clear_imem(ECALL);
    imem[0] = enc_addi(5'd3, 5'd0, 12'd12);
    imem[1] = enc_sw(5'd3, 5'd0, 12'd8);
    imem[2] = enc_lw(5'd4, 5'd0, 12'd8);
    ready_delay = 3;
    apply_reset();
    base = n_req;
    run_until_halt(200, cyc);
    check("t3_halt_cycle", 32'(cyc), 32'd21);
    check("t3_nreq", 32'(n_req - base), 32'd2);
    if (n_req - base == 2) begin
      check("t3_sw_len", req_lens[base], 32'd4);
      check("t3_sw_addr", req_addrs[base], 32'd8);
      check("t3_sw_we", {31'd0, req_wes[base]}, 32'd1);
      check("t3_lw_len", req_lens[base+1], 32'd4);
      check("t3_lw_we", {31'd0, req_wes[base+1]}, 32'd0);
    end
    check("t3_mem", dmem[2], 32'd12);
    check_reg("t3_x4", 5'd4, 32'd12);
    check("t3_retired", retired_count, 32'd3);

    // Reset while a load waits in MEM
    clear_imem(ECALL);
    imem[0] = enc_addi(5'd5, 5'd0, 12'd9);
    imem[1] = enc_lw(5'd6, 5'd0, 12'd0);
    ready_delay = 1000;
    apply_reset();
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("t4_req_held", {31'd0, dmem_req}, 32'd1);
    check("t4_retired_pre", retired_count, 32'd1);
    reset = 1'b1;
    #1;
    check("t4_req_abandon", {31'd0, dmem_req}, 32'd0);
    check("t4_retired_rst", retired_count, 32'd0);
    check_reg("t4_x5_cleared", 5'd5, 32'd0);
    check_reg("t4_x6_unwritten", 5'd6, 32'd0);
    ready_delay = 0;

    // beq x1,x1,-4 loop walking PC downward, then asynchronous reset
    clear_imem(enc_br(3'b000, 5'd1, 5'd1, 13'h1FFC));
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("t5_pc_%0d", k), imem_addr, PC_RST - 32'(4 * k));
      check($sformatf("t5_ret_%0d", k), retired_count, 32'(k));
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_async_pc", imem_addr, PC_RST);
    check("t5_async_retired", retired_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_restart_pc", imem_addr, PC_RST - 32'd4);

    // x0 and out-of-range writes are dropped with NUM_REGS=16
    clear_imem(ECALL);
    imem[0] = enc_addi(5'd0, 5'd0, 12'd9);
    imem[1] = enc_addi(5'd20, 5'd0, 12'd1);
    imem[2] = enc_addi(5'd15, 5'd0, 12'hFFF);
    apply_reset();
    run_until_halt(100, cyc);
    check_reg("t6_x0", 5'd0, 32'd0);
    check_reg("t6_x20", 5'd20, 32'd0);
    check_reg("t6_x4_alias", 5'd4, 32'd0);
    check_reg("t6_x15", 5'd15, 32'hFFFF_FFFF);
    check("t6_retired", retired_count, 32'd3);

    // bne x1,x2,8 with x1 != x2
    clear_imem(ECALL);
    imem[0] = enc_addi(5'd1, 5'd0, 12'd1);
    imem[1] = enc_addi(5'd2, 5'd0, 12'd2);
    imem[2] = enc_br(3'b001, 5'd1, 5'd2, 13'd8);
    imem[3] = enc_addi(5'd7, 5'd0, 12'd7);
    apply_reset();
    run_until_halt(100, cyc);
    check_reg("t7_skipped", 5'd7, 32'd0);
`ifdef MULTICYCLE_BNE_EN
    check("t7_pc", imem_addr, PC_RST + 32'h10);
    check("t7_retired", retired_count, 32'd3);
`else
    check("t7_pc", imem_addr, PC_RST + 32'h8);
    check("t7_retired", retired_count, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
